// File: rtl/ws2812_encoder_if.sv
// Frame-RAM read port, start request and WS2812 line/status outputs of one encoder.
// master = encoder side, slave = frame controller / RAM side.
interface ws2812_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              frame_rdy_in;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [23:0]       rd_data_in;
  logic              ws2812_data_out;
  logic              busy_out;
  logic              frame_done_out;

  modport master (
    input  frame_rdy_in,
    input  rd_data_in,
    output rd_addr_out,
    output ws2812_data_out,
    output busy_out,
    output frame_done_out
  );

  modport slave (
    output frame_rdy_in,
    output rd_data_in,
    input  rd_addr_out,
    input  ws2812_data_out,
    input  busy_out,
    input  frame_done_out
  );
endinterface

// File: rtl/ws2812_encoder.sv
// Streams PIXEL_CNT GRB words from a registered frame RAM onto one WS2812 line, then a latch gap.
// Optional macro WS2812_PENDING_EN: queue one start request that arrives while busy.
module ws2812_encoder #(
  parameter int PIXEL_CNT  = 64,
  parameter int ADDR_W     = 6,
  parameter int BIT_CYCLES = 100,
  parameter int T0H_CYCLES = 32,
  parameter int T1H_CYCLES = 64,
  parameter int RST_CYCLES = 6400
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  ws2812_encoder_if.master   bus
);

  localparam int CYC_MAX = (RST_CYCLES > BIT_CYCLES) ? RST_CYCLES : BIT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX);
  localparam int PIX_W   = $clog2(PIXEL_CNT);

  localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] RST_PRE  = CYC_W'(RST_CYCLES - 2);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYCLES);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_CNT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, GAP} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [4:0]       bit_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [23:0]      shift_reg;
  logic [23:0]      hold_reg;
  logic             bit_end;
  logic             gap_end;
  logic             restart;

  assign bit_end = (state == SEND) && (cyc_cnt == BIT_LAST);
  assign gap_end = (state == GAP)  && (cyc_cnt == RST_LAST);

`ifdef WS2812_PENDING_EN
  logic pending;

  // One-deep request latch; any number of pulses during a frame collapse into one.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                               pending <= 1'b0;
    else if (gap_end)                            pending <= 1'b0;
    else if (bus.busy_out && bus.frame_rdy_in)   pending <= 1'b1;
  end

  assign restart = pending | bus.frame_rdy_in;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state               <= IDLE;
      bus.busy_out        <= 1'b0;
      bus.frame_done_out  <= 1'b0;
      bus.ws2812_data_out <= 1'b0;
      bus.rd_addr_out     <= '0;
      cyc_cnt             <= '0;
      bit_cnt             <= '0;
      pix_cnt             <= '0;
    end else begin
      bus.frame_done_out  <= 1'b0;
      bus.ws2812_data_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_rdy_in) begin
            state           <= FETCH;
            bus.busy_out    <= 1'b1;
            bus.rd_addr_out <= '0;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          pix_cnt         <= '0;
          bit_cnt         <= '0;
          cyc_cnt         <= '0;
          bus.rd_addr_out <= ADDR_W'(1);
          state           <= SEND;
        end
        SEND: begin
          bus.ws2812_data_out <= (cyc_cnt < (shift_reg[23] ? T1H : T0H));
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              // Address stays put after the final prefetch; that word is never used.
              if (pix_cnt == PIX_LAST) begin
                state <= GAP;
              end else begin
                pix_cnt         <= pix_cnt + PIX_W'(1);
                bus.rd_addr_out <= bus.rd_addr_out + ADDR_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        GAP: begin
          // Done is set one count early so it is high during the last gap cycle.
          bus.frame_done_out <= (cyc_cnt == RST_PRE);
          if (gap_end) begin
            cyc_cnt <= '0;
            if (restart) begin
              state           <= FETCH;
              bus.rd_addr_out <= '0;
            end else begin
              state        <= IDLE;
              bus.busy_out <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel data path: word for pixel n+1 is captured one cycle into pixel n, after the RAM latency.
  always_ff @(posedge clk_in) begin
    if (state == LOAD)
      shift_reg <= bus.rd_data_in;
    else if (bit_end)
      shift_reg <= (bit_cnt == 5'd23) ? hold_reg : {shift_reg[22:0], 1'b0};
    if ((state == SEND) && (bit_cnt == 5'd0) && (cyc_cnt == CYC_W'(1)))
      hold_reg <= bus.rd_data_in;
  end

endmodule

// File: doc/ws2812_encoder.md
# ws2812_encoder

Serialises one layer's pixel buffer onto a single WS2812 data line. It sits directly downstream of the per-layer frame RAM. On `frame_rdy_in` it reads `PIXEL_CNT` 24-bit GRB words through a synchronous read port and drives the WS2812 one-wire waveform MSB first with no gaps between bits. It then holds the line low for the latch/reset gap and pulses `frame_done_out`.

## Interface
- `PIXEL_CNT`, 64: pixels per frame (≥2)
- `ADDR_W`, 6: read address width; `2**ADDR_W` ≥ `PIXEL_CNT`
- `BIT_CYCLES`, 100: clocks per data bit (1.25 µs at 80 MHz sys_clk)
- `T0H_CYCLES`, 32: high time for a 0 bit
- `T1H_CYCLES`, 64: high time for a 1 bit; `T0H_CYCLES` < `T1H_CYCLES` < `BIT_CYCLES`
- `RST_CYCLES`, 6400: post-frame low gap (80 µs)

Ports:
- `clk_in` in 1: sys_clk; the only clock
- `rst_n_in` in 1: reset; synchronous, active-low
- `frame_rdy_in` in 1: one-cycle start request
- `rd_addr_out` out `ADDR_W`: frame RAM read address
- `rd_data_in` in 24: RAM read data, valid one cycle after address (registered RAM)
- `ws2812_data_out` out 1: registered WS2812 line
- `busy_out` out 1: high from frame start until end of reset gap
- `frame_done_out` out 1: one-cycle pulse at end of reset gap

## Operation
- States: IDLE, FETCH, LOAD, SEND, GAP.
- IDLE: `frame_rdy_in`=1 → FETCH, `busy_out`←1, `rd_addr_out`←0.
- FETCH: one cycle; RAM registers word 0.
- LOAD: `shift_reg`←`rd_data_in`, `pix_cnt`←0, `bit_cnt`←0, `cyc_cnt`←0, `rd_addr_out`←1; → SEND.
- SEND: `cyc_cnt` counts 0..`BIT_CYCLES`-1.
  - `ws2812_data_out`←(`cyc_cnt` < (`shift_reg[23]` ? `T1H_CYCLES` : `T0H_CYCLES`)).
  - At `cyc_cnt`=`BIT_CYCLES`-1: shift left, `bit_cnt`+1.
  - Prefetch: at `bit_cnt`=0, `cyc_cnt`=1 the next word is captured into `hold_reg`.
  - At end of bit 23: if `pix_cnt`=`PIXEL_CNT`-1 → GAP. Otherwise `shift_reg`←`hold_reg`, `pix_cnt`+1, `rd_addr_out`+1, with no idle cycle inserted.
- `rd_addr_out` never exceeds `PIXEL_CNT` and is held after the last prefetch. The prefetched word beyond the last pixel is discarded.
- GAP: line low; `cyc_cnt` counts 0..`RST_CYCLES`-1. On the last count: `frame_done_out`←1 for one cycle, `busy_out`←0, → IDLE (or FETCH if pending, see Configuration).
- `frame_rdy_in` outside IDLE is never accepted directly; handling is per Configuration.

## Timing
- Reset values: `ws2812_data_out`=0, `busy_out`=0, `frame_done_out`=0, `rd_addr_out`=0, state IDLE, pending=0.
- `rst_n_in`=0 sampled mid-frame: all outputs take reset values at that edge. The line drops low immediately and any pending request is cleared.
- `frame_rdy_in` sampled high at edge E0:
  - `busy_out`=1 after E0.
  - `rd_data_in` is captured at E2.
  - `ws2812_data_out` rises after E3 (first SEND cycle).
- Each bit is exactly `BIT_CYCLES` clocks.
- Frame line time is exactly `24*PIXEL_CNT*BIT_CYCLES` cycles of SEND, then `RST_CYCLES` of GAP.
- `frame_done_out` is coincident with the last GAP cycle. `busy_out` falls on the following edge.
- RAM contents must be stable from E0 until the last prefetch. The encoder does not buffer the frame.

## Configuration
- `WS2812_PENDING_EN` defined:
  - A `frame_rdy_in` pulse seen while `busy_out`=1 sets a one-deep pending flag; further pulses while pending are merged.
  - At the end of GAP with pending set: → FETCH directly, pending cleared, `busy_out` stays 1, `frame_done_out` still pulses.
- Not defined: `frame_rdy_in` while busy is ignored; no pending logic is synthesised.

## Test plan
- `PIXEL_CNT`=2, words 0xFF0000, 0x000001, one start pulse → 48 bits.
  - First 8 highs are 64 cycles, the next 39 highs are 32 cycles, the last high is 64 cycles.
  - Every period is 100 cycles; then 6400 low cycles; `frame_done_out` pulses once.
- Start at E0 → `rd_addr_out`=0 at E0..E2, rising edge after E3, `rd_addr_out`=1 after E2; no bit period ≠ 100 cycles at the pixel boundary.
- `rst_n_in` low for 1 cycle during pixel 1, bit 5 → next cycle line=0, busy=0, addr=0. A new start produces a full, correct frame.
- Start pulse during SEND, with `WS2812_PENDING_EN`: second frame's first rise occurs 4 cycles after the `frame_done_out` edge, and `busy_out` never drops. Without the macro: no second frame, busy drops.
- Three start pulses during one frame with `WS2812_PENDING_EN` → exactly one extra frame.
- Start pulse coincident with the last GAP cycle → treated as busy-time request (pending/ignored per macro). A pulse the cycle after `busy_out` falls starts normally.
